mmio_serial: RTL and testbench
==============================

# mmio_serial

Synthesizable, parametrised memory-mapped serial port that replaces the simulation-only serial device on the core's operand bus. Two independent FIFOs decouple the core from an external byte stream: TX is drained by a valid/ready handshake and RX is filled by a valid strobe. A status register exposes occupancy and sticky overflow flags. The block sits beside the RAM on the shared operand bus (enable/rw/addr/data) and decodes a two-word window at BASE.

## Interface
Parameters:
- BASE, 32: word address of the data register; the status register is at BASE+1.
- WIDTH, 8: character width in bits, 1..32.
- DEPTH, 16: entries per FIFO; a power of two, 2..128.

Ports:
- clk  input  1: system clock; all state updates on the falling edge.
- reset_n  input  1: reset, asynchronous and active-low.
- enable  input  1: bus access strobe.
- rw  input  1: 1 = write, 0 = read.
- addr  input  32: word address.
- data  inout  32: shared bus data.
- tx_data  output  WIDTH: head of the TX FIFO.
- tx_valid  output  1: TX FIFO is not empty.
- tx_ready  input  1: sink accepts tx_data on this edge.
- rx_data  input  WIDTH: incoming character.
- rx_valid  input  1: push rx_data on this edge.

## Operation
- Select is `enable && (addr == BASE || addr == BASE+1)`. Addresses outside the window are ignored, and data is 'bz.
- Write to BASE: pushes data[WIDTH-1:0] into TX. If TX is full, the write is dropped and tx_ovf is set.
- Read from BASE: drives data with the zero-extended RX head and pops it. If RX is empty, drives 32'hFFFF_FFFF and does not pop.
- Status word, read at BASE+1:
  - bit0: rx_nonempty
  - bit1: tx_nonfull
  - bit2: tx_ovf (sticky)
  - bit3: rx_ovf (sticky)
  - [15:8]: rx_count
  - [23:16]: tx_count
  - all other bits: 0
- Write to BASE+1: write-1-to-clear for bits 2 and 3; all other bits are ignored.
- RX push: when rx_valid is high and RX is full, the character is dropped and rx_ovf is set.
- TX pop: occurs on an edge where tx_valid && tx_ready.
- Simultaneous push and pop on the same FIFO:
  - both take effect and the count is unchanged;
  - when full, the push is accepted because the pop frees the slot;
  - when empty, the pop is a no-op and the push lands.
- A flag set and a W1C clear on the same edge: set wins.
- Pointers wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits wide and are zero-extended into the status fields.

## Timing
- Read data on the bus is combinational from select, addr and FIFO state, valid within the same clock phase, in the same way as the RAM. The pop commits at the falling edge.
- A TX write committed at edge n is visible on tx_valid/tx_data after edge n, so the first transfer is possible at edge n+1.
- An RX push at edge n is readable in the cycle after edge n.
- Status reflects state after the last edge; there is no extra latency.
- Reset behaviour (asynchronous, mid-operation included): FIFOs are emptied, both flags are cleared, and tx_valid=0. tx_data is don't-care but must be deterministic 0. data is 'bz.
- Release of reset is synchronised to the next falling edge.

## Structure
- Shared header `serial_defs.vh` holds:
  - register offsets (DATA=0, STAT=1);
  - status bit positions and field ranges;
  - the empty-read value 32'hFFFF_FFFF.
- One sub-module, `fifo_sync`, is instantiated twice (TX, RX):
  - parameters: WIDTH, DEPTH;
  - ports: push, pop, din, dout, full, empty, count;
  - behaviour: first-word fall-through, asynchronous active-low reset.
- The top-level block contains only address decode, the bus mux/tristate, the flag registers and the status assembly.

## Test plan
- Reset, then read BASE+1 -> 32'h0000_0002; tx_valid=0.
- Write 'A','B','C' to BASE with tx_ready=0, then hold tx_ready=1 -> tx_data presents 0x41, 0x42, 0x43 on consecutive edges; tx_count goes 3→0; tx_valid drops after the third edge.
- With DEPTH=16 and tx_ready=0, make 17 writes -> status tx_count=16, bit1=0, bit2=1. Write 0x4 to BASE+1 -> bit2=0 and the count is unchanged.
- Pulse rx_valid with 0x5A -> BASE+1 reads 32'h0000_0103. Read BASE -> 0x0000_005A. A second read of BASE -> 32'hFFFF_FFFF and the count stays 0.
- Fill RX to 16, then on one edge assert both rx_valid (0x77) and a read of BASE -> the count stays 16, rx_ovf=0, and 0x77 is the last character read back.
- Assert reset_n=0 mid-transfer while tx_valid=1 and RX holds 5 entries -> all counts 0, flags 0 and tx_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mmio_serial_pkg                                                  |
// | Brief   : Register offsets, status layout and empty-read value for the     |
// |           memory-mapped serial port.                                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mmio_serial_pkg;

    localparam logic [31:0] c_ofs_data          = 32'd0;
    localparam logic [31:0] c_ofs_stat          = 32'd1;

    localparam int          c_stat_rx_nonempty  = 0;
    localparam int          c_stat_tx_nonfull   = 1;
    localparam int          c_stat_tx_ovf       = 2;
    localparam int          c_stat_rx_ovf       = 3;
    localparam int          c_stat_rxcnt_lsb    = 8;
    localparam int          c_stat_rxcnt_msb    = 15;
    localparam int          c_stat_txcnt_lsb    = 16;
    localparam int          c_stat_txcnt_msb    = 23;

    localparam logic [31:0] c_empty_read        = 32'hFFFF_FFFF;

    function automatic logic [31:0] build_status(
        input logic       rx_nonempty,
        input logic       tx_nonfull,
        input logic       tx_ovf,
        input logic       rx_ovf,
        input logic [7:0] rx_cnt,
        input logic [7:0] tx_cnt
    );
        logic [31:0] w_s;
        w_s                                       = '0;
        w_s[c_stat_rx_nonempty]                   = rx_nonempty;
        w_s[c_stat_tx_nonfull]                    = tx_nonfull;
        w_s[c_stat_tx_ovf]                        = tx_ovf;
        w_s[c_stat_rx_ovf]                        = rx_ovf;
        w_s[c_stat_rxcnt_msb:c_stat_rxcnt_lsb]    = rx_cnt;
        w_s[c_stat_txcnt_msb:c_stat_txcnt_lsb]    = tx_cnt;
        return w_s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_serial_fifo_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fifo_sync                                                        |
// | Brief   : First-word fall-through FIFO, falling-edge clocked, async        |
// |           active-low reset; push into a full FIFO succeeds with a pop.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    // Storage is not reset, so gate the head to keep it a known 0 when empty
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mmio_serial                                                      |
// | Brief   : Memory-mapped serial port: data/status window on the operand     |
// |           bus, TX and RX FIFOs, sticky overflow flags.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mmio_serial
    import mmio_serial_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'd32,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              rw,
    input  logic [31:0]       addr,
    inout  wire  [31:0]       data,
    output logic [WIDTH-1:0]  tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [WIDTH-1:0]  rx_data,
    input  logic              rx_valid
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             r_rst_n;
    logic             r_tx_ovf;
    logic             r_rx_ovf;
    logic             w_sel_data;
    logic             w_sel_stat;
    logic             w_tx_wr;
    logic             w_tx_pop;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [CW-1:0]    w_tx_count;
    logic             w_rx_rd;
    logic             w_rx_pop;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic [CW-1:0]    w_rx_count;
    logic [WIDTH-1:0] w_rx_dout;
    logic             w_stat_wr;
    logic             w_tx_ovf_set;
    logic             w_rx_ovf_set;
    logic [31:0]      w_status;
    logic [31:0]      w_rdata;
    logic             w_drive;
    logic             w_unused_data;

    // Assert asynchronously, release on the next falling edge
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_n <= 1'b0;
        else          r_rst_n <= 1'b1;
    end

    assign w_sel_data = enable && (addr == BASE + c_ofs_data);
    assign w_sel_stat = enable && (addr == BASE + c_ofs_stat);
    assign w_tx_wr    = w_sel_data && rw;
    assign w_rx_rd    = w_sel_data && !rw;
    assign w_stat_wr  = w_sel_stat && rw;
    assign w_tx_pop   = tx_valid && tx_ready;
    assign w_rx_pop   = w_rx_rd && !w_rx_empty;
    assign tx_valid   = !w_tx_empty;

    // A pop on the same edge frees the slot, so only a pop-less full push overflows
    assign w_tx_ovf_set = w_tx_wr && w_tx_full && !w_tx_pop;
    assign w_rx_ovf_set = rx_valid && w_rx_full && !w_rx_pop;

    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset_n (r_rst_n),
        .push    (w_tx_wr),
        .pop     (w_tx_pop),
        .din     (data[WIDTH-1:0]),
        .dout    (tx_data),
        .full    (w_tx_full),
        .empty   (w_tx_empty),
        .count   (w_tx_count)
    );

    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset_n (r_rst_n),
        .push    (rx_valid),
        .pop     (w_rx_pop),
        .din     (rx_data),
        .dout    (w_rx_dout),
        .full    (w_rx_full),
        .empty   (w_rx_empty),
        .count   (w_rx_count)
    );

    always_ff @(negedge clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_tx_ovf_set)                             r_tx_ovf <= 1'b1;
            else if (w_stat_wr && data[c_stat_tx_ovf])    r_tx_ovf <= 1'b0;
            if (w_rx_ovf_set)                             r_rx_ovf <= 1'b1;
            else if (w_stat_wr && data[c_stat_rx_ovf])    r_rx_ovf <= 1'b0;
        end
    end

    assign w_status = build_status(!w_rx_empty, !w_tx_full, r_tx_ovf, r_rx_ovf,
                                   8'(w_rx_count), 8'(w_tx_count));

    assign w_rdata  = w_sel_stat ? w_status
                    : (w_rx_empty ? c_empty_read : 32'(w_rx_dout));
    assign w_drive  = r_rst_n && !rw && (w_sel_data || w_sel_stat);
    assign data     = w_drive ? w_rdata : 'z;

    assign w_unused_data = &{1'b0, data};

endmodule
`default_nettype wire

// File: tb/tb_mmio_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mmio_serial                                                   |
// | Brief   : Directed self-checking bench for mmio_serial with TX/RX queues.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mmio_serial;

    localparam logic [31:0] BASE  = 32'd32;
    localparam int          WIDTH = 8;
    localparam int          DEPTH = 16;

    logic              clk = 1'b1;
    logic              reset_n;
    logic              enable;
    logic              rw;
    logic [31:0]       addr;
    wire  [31:0]       data;
    logic [31:0]       drv;
    logic              drv_en;
    logic [WIDTH-1:0]  tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [WIDTH-1:0]  rx_data;
    logic              rx_valid;

    int                checks = 0;
    int                errors = 0;
    logic [31:0]       tx_q[$];
    logic [31:0]       rx_q[$];
    logic [31:0]       rd;

    always #5 clk = ~clk;

    assign data = drv_en ? drv : 'z;

    mmio_serial #(.BASE(BASE), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .rw       (rw),
        .addr     (addr),
        .data     (data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        enable = 1'b1; rw = 1'b1; addr = a; drv = d; drv_en = 1'b1;
        @(negedge clk);
        #1;
        enable = 1'b0; rw = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
        @(posedge clk);
        enable = 1'b1; rw = 1'b0; addr = a;
        #1;
        r = data;
        @(negedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(posedge clk);
        rx_valid = 1'b1; rx_data = d;
        if (rx_q.size() < DEPTH) rx_q.push_back(32'(d));
        @(negedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] d);
        if (tx_q.size() < DEPTH) tx_q.push_back(32'(d));
        bus_write(BASE, 32'(d));
    endtask

    task automatic tx_drain();
        int n;
        n = tx_q.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            tx_ready = 1'b1;
            #1;
            chk("tx_valid_drain", 32'(tx_valid), 32'd1);
            chk("tx_data", 32'(tx_data), tx_q.pop_front());
            @(negedge clk);
        end
        #1;
        chk("tx_valid_empty", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;
    endtask

    task automatic rx_read_expect();
        bus_read(BASE, rd);
        chk("rx_read", rd, (rx_q.size() > 0) ? rx_q.pop_front() : 32'hFFFF_FFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; rw = 1'b0; addr = '0; drv = '0; drv_en = 1'b0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        #12;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);

        bus_read(BASE + 1, rd);
        chk("stat_after_reset", rd, 32'h0000_0002);
        chk("tx_valid_idle", 32'(tx_valid), 32'd0);

        // Outside the window: no push, no pop
        bus_write(BASE + 2, 32'h55);
        bus_read(BASE + 1, rd);
        chk("stat_no_stray_push", rd, 32'h0000_0002);

        tx_write(8'h41); tx_write(8'h42); tx_write(8'h43);
        bus_read(BASE + 1, rd);
        chk("stat_tx3", rd, 32'h0003_0002);
        #1;
        chk("tx_head_A", 32'(tx_data), 32'h41);
        tx_drain();
        bus_read(BASE + 1, rd);
        chk("stat_tx_drained", rd, 32'h0000_0002);

        for (int i = 0; i < 17; i++) tx_write(8'(8'h10 + i));
        bus_read(BASE + 1, rd);
        chk("stat_tx_full_ovf", rd, 32'h0010_0004);
        bus_write(BASE + 1, 32'h4);
        bus_read(BASE + 1, rd);
        chk("stat_tx_ovf_clr", rd, 32'h0010_0000);
        tx_drain();

        rx_push(8'h5A);
        bus_read(BASE + 1, rd);
        chk("stat_rx1", rd, 32'h0000_0103);
        bus_read(BASE + 2, rd);
        bus_read(BASE + 1, rd);
        chk("stat_no_stray_pop", rd, 32'h0000_0103);
        rx_read_expect();
        bus_read(BASE, rd);
        chk("rx_empty_read", rd, 32'hFFFF_FFFF);
        bus_read(BASE + 1, rd);
        chk("stat_rx_empty", rd, 32'h0000_0002);

        for (int i = 0; i < 16; i++) rx_push(8'(8'h60 + i));
        bus_read(BASE + 1, rd);
        chk("stat_rx_full", rd, 32'h0000_1003);
        // Full RX: push and pop on the same edge
        @(posedge clk);
        enable = 1'b1; rw = 1'b0; addr = BASE; rx_valid = 1'b1; rx_data = 8'h77;
        #1;
        chk("rx_read_simul", data, rx_q.pop_front());
        rx_q.push_back(32'h77);
        @(negedge clk);
        #1;
        enable = 1'b0; rx_valid = 1'b0;
        bus_read(BASE + 1, rd);
        chk("stat_rx_simul", rd, 32'h0000_1003);
        for (int i = 0; i < 16; i++) rx_read_expect();
        chk("rx_queue_empty", 32'(rx_q.size()), 32'd0);

        for (int i = 0; i < 17; i++) rx_push(8'(8'h80 + i));
        bus_read(BASE + 1, rd);
        chk("stat_rx_ovf", rd, 32'h0000_100B);
        for (int i = 0; i < 11; i++) rx_read_expect();
        tx_write(8'h31); tx_write(8'h32); tx_write(8'h33);
        bus_read(BASE + 1, rd);
        chk("stat_pre_reset", rd, 32'h0003_050B);

        // Reset between edges while a TX transfer is offered
        @(posedge clk);
        tx_ready = 1'b1;
        #1;
        chk("tx_valid_pre_reset", 32'(tx_valid), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("tx_valid_async_rst", 32'(tx_valid), 32'd0);
        chk("tx_data_async_rst", 32'(tx_data), 32'd0);
        tx_ready = 1'b0;
        tx_q.delete(); rx_q.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        bus_read(BASE + 1, rd);
        chk("stat_after_midreset", rd, 32'h0000_0002);
        bus_read(BASE, rd);
        chk("rx_empty_after_reset", rd, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
